// File: rtl/inst_cache_pkg.sv
// ---------------------------------------------------------------------------
// inst_cache_pkg
//   Shared definitions for the direct-mapped instruction cache: address field
//   widths, default geometry, FSM state encoding and a helper that derives
//   the tag width from the geometry.
//   Optional feature macro: ICACHE_STATS_EN (hit/miss counters, see inst_cache).
// ---------------------------------------------------------------------------
package inst_cache_pkg;

  localparam int ICACHE_ADDR_W        = 32;
  localparam int ICACHE_WORD_W        = 32;
  localparam int ICACHE_OFF_BITS      = 2;   // byte offset inside a 32-bit word
  localparam int ICACHE_INDEX_BITS    = 6;   // 64 lines
  localparam int ICACHE_LINE_WORDS_LG = 2;   // 4 words per line

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REFILL  = 2'b01,
    ST_RESPOND = 2'b10
  } icache_state_e;

  // Tag = whatever address bits are left above index, word and byte offset.
  function automatic int icache_tag_bits(input int index_bits, input int line_words_lg);
    return ICACHE_ADDR_W - index_bits - line_words_lg - ICACHE_OFF_BITS;
  endfunction

endpackage

// File: rtl/inst_cache_if.sv
// ---------------------------------------------------------------------------
// inst_cache_if
//   Bundles the fetcher-side and memory-side signals of the instruction cache.
//   slave  : the cache's view (fetch requests and memory data in, responses
//            and memory requests out).
//   master : the environment's view (fetcher + memory controller).
//   Signals:
//     _clear, _fetch_valid, _fetch_addr[31:0]         fetcher -> cache
//     _inst_ready_out, _inst_out[31:0], _icache_busy  cache -> fetcher
//     _mem_req, _mem_addr[31:0]                       cache -> memory
//     _mem_busy, _mem_data_ready, _mem_data[31:0]     memory -> cache
//     _hit_cnt[31:0], _miss_cnt[31:0]                 only with ICACHE_STATS_EN
// ---------------------------------------------------------------------------
interface inst_cache_if;
  logic        _clear;
  logic        _fetch_valid;
  logic [31:0] _fetch_addr;
  logic        _inst_ready_out;
  logic [31:0] _inst_out;
  logic        _icache_busy;
  logic        _mem_busy;
  logic        _mem_req;
  logic [31:0] _mem_addr;
  logic        _mem_data_ready;
  logic [31:0] _mem_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] _hit_cnt;
  logic [31:0] _miss_cnt;

  modport slave (
    input  _clear, _fetch_valid, _fetch_addr, _mem_busy, _mem_data_ready, _mem_data,
    output _inst_ready_out, _inst_out, _icache_busy, _mem_req, _mem_addr, _hit_cnt, _miss_cnt
  );
  modport master (
    output _clear, _fetch_valid, _fetch_addr, _mem_busy, _mem_data_ready, _mem_data,
    input  _inst_ready_out, _inst_out, _icache_busy, _mem_req, _mem_addr, _hit_cnt, _miss_cnt
  );
`else
  modport slave (
    input  _clear, _fetch_valid, _fetch_addr, _mem_busy, _mem_data_ready, _mem_data,
    output _inst_ready_out, _inst_out, _icache_busy, _mem_req, _mem_addr
  );
  modport master (
    output _clear, _fetch_valid, _fetch_addr, _mem_busy, _mem_data_ready, _mem_data,
    input  _inst_ready_out, _inst_out, _icache_busy, _mem_req, _mem_addr
  );
`endif
endinterface

// File: rtl/inst_cache_tag_array.sv
// ---------------------------------------------------------------------------
// icache_tag_array
//   Valid/tag store for the direct-mapped instruction cache.
//   Lookup is combinational (o_hit), writes are synchronous. Only the valid
//   bits are reset; tags are don't-care while their line is invalid.
//   Ports:
//     clk_in, rst_in            clock, synchronous active-high reset
//     i_rd_index, i_rd_tag      lookup address fields
//     o_hit                     line valid and tag matches
//     i_wr_en                   write strobe (already qualified by enable)
//     i_wr_index, i_wr_tag      line to update and its new tag
//     i_wr_valid                new valid bit (0 = invalidate, 1 = fill done)
// ---------------------------------------------------------------------------
module icache_tag_array #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 22
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  input  logic [TAG_BITS-1:0]   i_rd_tag,
  output logic                  o_hit,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic                  i_wr_valid
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag [LINES];

  // Valid bits: cleared by reset, updated on every tag-array write.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid <= {LINES{1'b0}};
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= i_wr_valid;
    end
  end

  // Tag storage: only written when a line becomes valid.
  always_ff @(posedge clk_in) begin
    if (i_wr_en && i_wr_valid) begin
      r_tag[i_wr_index] <= i_wr_tag;
    end
  end

  assign o_hit = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);

endmodule

// File: rtl/inst_cache.sv
// ---------------------------------------------------------------------------
// inst_cache
//   Direct-mapped, read-only instruction cache. A hit answers one cycle after
//   the request; a miss refills the whole line word by word from memory and
//   then answers with the requested word. A ROB flush (_clear) kills the
//   response of an outstanding fetch but lets an in-flight refill finish.
//   Ports:
//     clk_in   system clock
//     rst_in   synchronous active-high reset
//     rdy_in   global enable; low freezes all state (memory data ignored)
//     bus      inst_cache_if.slave (fetch request/response, memory port)
//   Optional: define ICACHE_STATS_EN to add bus._hit_cnt / bus._miss_cnt,
//   counting accepted requests, wrapping at 2^32.
// ---------------------------------------------------------------------------
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS    = ICACHE_INDEX_BITS,
  parameter int LINE_WORDS_LG = ICACHE_LINE_WORDS_LG
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  inst_cache_if.slave  bus
);

  localparam int TAG_BITS   = icache_tag_bits(INDEX_BITS, LINE_WORDS_LG);
  localparam int DIDX_W     = INDEX_BITS + LINE_WORDS_LG;
  localparam int DATA_DEPTH = 1 << DIDX_W;

  // Fetch address fields
  logic [LINE_WORDS_LG-1:0] w_f_word;
  logic [INDEX_BITS-1:0]    w_f_index;
  logic [TAG_BITS-1:0]      w_f_tag;
  logic                     w_unused;

  assign w_f_word  = bus._fetch_addr[LINE_WORDS_LG+1:2];
  assign w_f_index = bus._fetch_addr[LINE_WORDS_LG+2 +: INDEX_BITS];
  assign w_f_tag   = bus._fetch_addr[ICACHE_ADDR_W-1 -: TAG_BITS];
  assign w_unused  = &{1'b0, bus._fetch_addr[1:0]};

  // State
  icache_state_e            r_state;
  logic [TAG_BITS-1:0]      r_lat_tag;
  logic [INDEX_BITS-1:0]    r_lat_index;
  logic [LINE_WORDS_LG-1:0] r_lat_word;
  logic [LINE_WORDS_LG-1:0] r_cnt;
  logic                     r_kill;
  logic                     r_inst_ready;
  logic [31:0]              r_inst_out;
  logic                     r_mem_req;
  logic [31:0]              r_mem_addr;
  logic [31:0]              r_data [DATA_DEPTH];

  logic                     w_hit;
  logic                     w_accept;
  logic                     w_fill_beat;
  logic                     w_last_beat;
  logic [31:0]              w_hit_word;
  logic [31:0]              w_resp_word;
  logic                     w_tag_we;
  logic [INDEX_BITS-1:0]    w_tag_wr_index;
  logic [TAG_BITS-1:0]      w_tag_wr_tag;
  logic                     w_tag_wr_valid;

  assign w_accept    = bus._fetch_valid && !bus._clear;
  // Data is only taken while our request is actually on the bus.
  assign w_fill_beat = (r_state == ST_REFILL) && r_mem_req && bus._mem_data_ready;
  assign w_last_beat = w_fill_beat && (r_cnt == {LINE_WORDS_LG{1'b1}});
  assign w_hit_word  = r_data[{w_f_index, w_f_word}];
  assign w_resp_word = r_data[{r_lat_index, r_lat_word}];

  icache_tag_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_tags (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_rd_index (w_f_index),
    .i_rd_tag   (w_f_tag),
    .o_hit      (w_hit),
    .i_wr_en    (w_tag_we),
    .i_wr_index (w_tag_wr_index),
    .i_wr_tag   (w_tag_wr_tag),
    .i_wr_valid (w_tag_wr_valid)
  );

  // Tag-array write: invalidate the victim line on a miss, validate it after the last beat.
  always_comb begin
    w_tag_we       = 1'b0;
    w_tag_wr_index = w_f_index;
    w_tag_wr_tag   = w_f_tag;
    w_tag_wr_valid = 1'b0;
    if (rdy_in && !rst_in) begin
      if ((r_state == ST_IDLE) && w_accept && !w_hit) begin
        w_tag_we       = 1'b1;
        w_tag_wr_index = w_f_index;
        w_tag_wr_tag   = w_f_tag;
        w_tag_wr_valid = 1'b0;
      end else if (w_last_beat) begin
        w_tag_we       = 1'b1;
        w_tag_wr_index = r_lat_index;
        w_tag_wr_tag   = r_lat_tag;
        w_tag_wr_valid = 1'b1;
      end else begin
        w_tag_we       = 1'b0;
      end
    end else begin
      w_tag_we = 1'b0;
    end
  end

  // Data array: written only by refill beats; contents need no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !rst_in && w_fill_beat) begin
      r_data[{r_lat_index, r_cnt}] <= bus._mem_data;
    end
  end

  // Main FSM with registered fetch-response and memory-request outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= ST_IDLE;
      r_lat_tag    <= {TAG_BITS{1'b0}};
      r_lat_index  <= {INDEX_BITS{1'b0}};
      r_lat_word   <= {LINE_WORDS_LG{1'b0}};
      r_cnt        <= {LINE_WORDS_LG{1'b0}};
      r_kill       <= 1'b0;
      r_inst_ready <= 1'b0;
      r_inst_out   <= 32'h0000_0000;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
    end else if (rdy_in) begin
      r_inst_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_hit) begin
              r_inst_ready <= 1'b1;
              r_inst_out   <= w_hit_word;
            end else begin
              r_lat_tag   <= w_f_tag;
              r_lat_index <= w_f_index;
              r_lat_word  <= w_f_word;
              r_cnt       <= {LINE_WORDS_LG{1'b0}};
              r_kill      <= 1'b0;
              r_state     <= ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          // A flush cannot abort memory mid-line; it only mutes the response.
          if (bus._clear) begin
            r_kill <= 1'b1;
          end
          if (r_mem_req) begin
            // Request held stable until the word arrives, then dropped one cycle.
            if (bus._mem_data_ready) begin
              r_mem_req <= 1'b0;
              r_cnt     <= r_cnt + LINE_WORDS_LG'(1'b1);
              if (r_cnt == {LINE_WORDS_LG{1'b1}}) begin
                r_state <= ST_RESPOND;
              end
            end
          end else if (!bus._mem_busy) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {r_lat_tag, r_lat_index, r_cnt, 2'b00};
          end
        end
        ST_RESPOND: begin
          if (!r_kill && !bus._clear) begin
            r_inst_ready <= 1'b1;
            r_inst_out   <= w_resp_word;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus._inst_ready_out = r_inst_ready;
  assign bus._inst_out       = r_inst_out;
  assign bus._icache_busy    = (r_state != ST_IDLE);
  assign bus._mem_req        = r_mem_req;
  assign bus._mem_addr       = r_mem_addr;

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Hit/miss statistics for requests accepted in IDLE.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hit_cnt  <= 32'h0000_0000;
      r_miss_cnt <= 32'h0000_0000;
    end else if (rdy_in && (r_state == ST_IDLE) && w_accept) begin
      if (w_hit) begin
        r_hit_cnt <= r_hit_cnt + 32'h0000_0001;
      end else begin
        r_miss_cnt <= r_miss_cnt + 32'h0000_0001;
      end
    end
  end

  assign bus._hit_cnt  = r_hit_cnt;
  assign bus._miss_cnt = r_miss_cnt;
`endif

endmodule
